// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Single borrow flop; registered result and ALU flags.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             a_msb;
  logic             b_msb;

  logic             a0;
  logic             b0;
  logic             d;
  logic             bout;
  logic [WIDTH-1:0] res_nx;

  assign a0     = a_sh[0];
  assign b0     = b_sh[0];
  assign d      = a0 ^ b0 ^ bin;
  assign bout   = (~a0 & b0) | (~(a0 ^ b0) & bin);
  assign res_nx = {d, res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      cnt      <= '0;
      bin      <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res  <= res_nx;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bin  <= bout;
          cnt  <= cnt + 1'b1;
          // MSB edge: publish result and flags together
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            diff     <= res_nx;
            borrow   <= bout;
            negative <= d;
            zero     <= (res_nx == '0);
            overflow <= (a_msb != b_msb) & (d != a_msb);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
